// File: rtl/DataTypes.sv
// ---------------------------------------------------------------------------
// DataTypes
// Shared types and constants for the req/ack handshake sender.
//   bit_t          : single-bit logic alias used for control strobes
//   hs_state_t     : sender FSM state, 2-bit encoding (code 2'b11 unused)
//   HS_SYNC_STAGES : default depth of the ack synchronizer
// ---------------------------------------------------------------------------
package DataTypes;

  typedef logic bit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } hs_state_t;

  localparam int HS_SYNC_STAGES = 2;

endpackage : DataTypes

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// N-stage single-bit synchronizer for a level arriving from another clock
// domain. Output is the input delayed by N clk edges.
// Ports:
//   clk      in  clock of the destination domain
//   reset    in  synchronous, active-low reset (clears every stage)
//   i_async  in  asynchronous level
//   o_sync   out synchronized level
// ---------------------------------------------------------------------------
module sync_chain
  import DataTypes::*;
#(
  parameter int N = HS_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  bit_t i_async,
  output bit_t o_sync
);

  logic [N-1:0] r_stage;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[N-2:0], i_async};
    end
  end

  assign o_sync = r_stage[N-1];

endmodule : sync_chain

// File: rtl/hs_req_sender.sv
// ---------------------------------------------------------------------------
// hs_req_sender
// Source side of a 4-phase req/ack handshake carrying one DATA_WIDTH word to
// another clock domain. The word is captured into data_out and req_out is
// raised; the remote side acknowledges, req_out falls, and once the ack has
// fallen again done pulses and the next word may be accepted.
//
// Optional feature macro: HS_TIMEOUT_EN
//   defined   : REQ is abandoned after TIMEOUT_CYCLES cycles without ack,
//               pulsing timeout_err and going through RELEASE as usual.
//   undefined : no counter, timeout_err is constant 0, REQ waits forever.
//
// Ports:
//   clk          in  clock
//   reset        in  synchronous, active-low reset
//   send_valid   in  local producer has a word
//   send_data    in  word to send
//   send_ready   out high only in IDLE (decoded from the state register)
//   req_out      out registered request level
//   data_out     out registered word, stable while req_out=1
//   ack_async    in  remote acknowledge, asynchronous to clk
//   done         out one-cycle pulse when a transfer completes
//   timeout_err  out one-cycle pulse on timeout
// ---------------------------------------------------------------------------
module hs_req_sender
  import DataTypes::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = HS_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_valid,
  input  logic [DATA_WIDTH-1:0] send_data,
  output logic                  send_ready,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_async,
  output logic                  done,
  output logic                  timeout_err
);

  hs_state_t             r_state;
  hs_state_t             w_state_next;
  logic                  r_req;
  logic                  w_req_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_next;
  logic                  r_done;
  logic                  w_done_next;
  bit_t                  w_ack_s;

  sync_chain #(
    .N(SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (ack_async),
    .o_sync  (w_ack_s)
  );

`ifdef HS_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_tout;
  logic             w_tout_next;
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and registered-output logic
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_data_next  = r_data;
    w_done_next  = 1'b0;
`ifdef HS_TIMEOUT_EN
    w_cnt_next   = r_cnt;
    w_tout_next  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (send_valid) begin
          w_data_next  = send_data;
          w_req_next   = 1'b1;
          w_state_next = REQ;
`ifdef HS_TIMEOUT_EN
          w_cnt_next   = '0;
`endif
        end
      end
      REQ: begin
        // A real ack takes priority over the terminal count.
        if (w_ack_s) begin
          w_req_next   = 1'b0;
          w_state_next = RELEASE;
        end
`ifdef HS_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          w_tout_next  = 1'b1;
          w_req_next   = 1'b0;
          w_state_next = RELEASE;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
`endif
      end
      RELEASE: begin
        if (!w_ack_s) begin
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_req_next   = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
`ifdef HS_TIMEOUT_EN
      r_cnt   <= '0;
      r_tout  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_req   <= w_req_next;
      r_data  <= w_data_next;
      r_done  <= w_done_next;
`ifdef HS_TIMEOUT_EN
      r_cnt   <= w_cnt_next;
      r_tout  <= w_tout_next;
`endif
    end
  end

  assign send_ready = (r_state == IDLE);
  assign req_out    = r_req;
  assign data_out   = r_data;
  assign done       = r_done;
`ifdef HS_TIMEOUT_EN
  assign timeout_err = r_tout;
`else
  assign timeout_err = 1'b0;
`endif

endmodule : hs_req_sender
